// File: rtl/line_raster_engine.sv
// line_raster_engine
// Bresenham line rasteriser for the AR overlay path. Accepts one segment
// (x0,y0)->(x1,y1) with a colour and emits one clipped pixel coordinate per
// cycle toward the frame-buffer writer, under valid/ready backpressure.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   seg_valid_in/ready_out  segment handshake (ready only while idle)
//   x0_in,y0_in,x1_in,y1_in signed endpoints (COORD_W)
//   color_in                segment colour
//   pix_valid_out/ready_in  pixel handshake
//   pix_x_out,pix_y_out     on-screen pixel coordinate
//   pix_color_out           pixel colour
//   done_out                1-cycle pulse when the segment finishes
//   abort_out               pulses with done_out when MAX_LEN steps were hit
//   dash_in                 (LINE_DASH_EN only) 16-bit dash pattern
//
// Build option: define LINE_DASH_EN to add dash_in; step i is emitted only
// when dash[i%16]=1, masked steps advance without a handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a segment, endpoints/colour latched on handshake
// SETUP | compute |dx|, -|dy|, step directions, initial error
// STEP  | present current point; advance on drop or pixel handshake
// DONE  | one-cycle done_out (abort_out when the step cap was reached)
module line_raster_engine #(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 4,
    parameter int H_RES   = 1024,
    parameter int V_RES   = 768,
    parameter int MAX_LEN = 4096
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       seg_valid_in,
    output logic                       seg_ready_out,
    input  logic signed [COORD_W-1:0]  x0_in,
    input  logic signed [COORD_W-1:0]  y0_in,
    input  logic signed [COORD_W-1:0]  x1_in,
    input  logic signed [COORD_W-1:0]  y1_in,
    input  logic [COLOR_W-1:0]         color_in,
`ifdef LINE_DASH_EN
    input  logic [15:0]                dash_in,
`endif
    output logic                       pix_valid_out,
    input  logic                       pix_ready_in,
    output logic [$clog2(H_RES)-1:0]   pix_x_out,
    output logic [$clog2(V_RES)-1:0]   pix_y_out,
    output logic [COLOR_W-1:0]         pix_color_out,
    output logic                       done_out,
    output logic                       abort_out
);

    localparam int W  = COORD_W + 2;
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic signed [W-1:0] H_LIM = W'(H_RES);
    localparam logic signed [W-1:0] V_LIM = W'(V_RES);
    localparam logic signed [W-1:0] ONE   = W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [W-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 abort_q, abort_d;
    logic [15:0]          dash_q, dash_d;

    logic signed [W-1:0]  dx_raw, dy_raw, dx_abs, dy_abs, err_n;
    logic signed [W:0]    e2;
    logic                 on_screen, dash_bit, emit, advance, at_end;

    always_comb begin
        dx_raw    = x1_q - x_q;
        dy_raw    = y1_q - y_q;
        dx_abs    = dx_raw[W-1] ? -dx_raw : dx_raw;
        dy_abs    = dy_raw[W-1] ? -dy_raw : dy_raw;
        // err is doubled one bit wider so 2*err can never wrap
        e2        = $signed({err_q, 1'b0});
        on_screen = !x_q[W-1] && (x_q < H_LIM) && !y_q[W-1] && (y_q < V_LIM);
`ifdef LINE_DASH_EN
        dash_bit  = dash_q[0];
`else
        dash_bit  = 1'b1;
`endif
        emit      = (state_q == S_STEP) && on_screen && dash_bit;
        advance   = (state_q == S_STEP) && (!emit || pix_ready_in);
        at_end    = (x_q == x1_q) && (y_q == y1_q);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        color_d  = color_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        dash_d   = dash_q;
        err_n    = err_q;
        case (state_q)
            S_IDLE: begin
                if (seg_valid_in) begin
                    x_d     = {{2{x0_in[COORD_W-1]}}, x0_in};
                    y_d     = {{2{y0_in[COORD_W-1]}}, y0_in};
                    x1_d    = {{2{x1_in[COORD_W-1]}}, x1_in};
                    y1_d    = {{2{y1_in[COORD_W-1]}}, y1_in};
                    color_d = color_in;
`ifdef LINE_DASH_EN
                    dash_d  = dash_in;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d     = dx_abs;
                dy_d     = -dy_abs;
                sx_neg_d = dx_raw[W-1];
                sy_neg_d = dy_raw[W-1];
                err_d    = dx_abs - dy_abs;
                cnt_d    = CW'(MAX_LEN);
                abort_d  = 1'b0;
                state_d  = S_STEP;
            end
            S_STEP: begin
                if (advance) begin
                    if (at_end) begin
                        abort_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        if (e2 >= $signed({dy_q[W-1], dy_q})) begin
                            err_n = err_n + dy_q;
                            x_d   = sx_neg_q ? x_q - ONE : x_q + ONE;
                        end
                        if (e2 <= $signed({dx_q[W-1], dx_q})) begin
                            err_n = err_n + dx_q;
                            y_d   = sy_neg_q ? y_q - ONE : y_q + ONE;
                        end
                        err_d  = err_n;
                        cnt_d  = cnt_q - CW'(1);
                        // rotating the pattern keeps dash_q[0] aligned to step index % 16
                        dash_d = {dash_q[0], dash_q[15:1]};
                        if (cnt_q == CW'(1)) begin
                            abort_d = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            color_q  <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            dash_q   <= '1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            color_q  <= color_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            dash_q   <= dash_d;
        end
    end

    assign seg_ready_out = (state_q == S_IDLE);
    assign pix_valid_out = emit;
    assign pix_x_out     = x_q[XW-1:0];
    assign pix_y_out     = y_q[YW-1:0];
    assign pix_color_out = color_q;
    assign done_out      = (state_q == S_DONE);
    assign abort_out     = (state_q == S_DONE) && abort_q;

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: a default instance plus a
// MAX_LEN=8 instance for the step-cap abort.
module tb_line_raster_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               seg_valid;
    logic signed [15:0] x0, y0, x1, y1;
    logic [3:0]         color;
    logic               pix_ready;
    logic               use2;

    logic       rdy_a, val_a, done_a, abort_a, rdy_b, val_b, done_b, abort_b;
    logic [9:0] px_a, py_a, px_b, py_b;
    logic [3:0] col_a, col_b;

    line_raster_engine dut_a (
        .clk_in(clk), .rst_in(rst_n), .seg_valid_in(seg_valid & ~use2), .seg_ready_out(rdy_a),
        .x0_in(x0), .y0_in(y0), .x1_in(x1), .y1_in(y1), .color_in(color),
`ifdef LINE_DASH_EN
        .dash_in(16'hFFFF),
`endif
        .pix_valid_out(val_a), .pix_ready_in(pix_ready), .pix_x_out(px_a), .pix_y_out(py_a),
        .pix_color_out(col_a), .done_out(done_a), .abort_out(abort_a)
    );

    line_raster_engine #(.MAX_LEN(8)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .seg_valid_in(seg_valid & use2), .seg_ready_out(rdy_b),
        .x0_in(x0), .y0_in(y0), .x1_in(x1), .y1_in(y1), .color_in(color),
`ifdef LINE_DASH_EN
        .dash_in(16'hFFFF),
`endif
        .pix_valid_out(val_b), .pix_ready_in(pix_ready), .pix_x_out(px_b), .pix_y_out(py_b),
        .pix_color_out(col_b), .done_out(done_b), .abort_out(abort_b)
    );

    wire       m_ready = use2 ? rdy_b   : rdy_a;
    wire       m_valid = use2 ? val_b   : val_a;
    wire       m_done  = use2 ? done_b  : done_a;
    wire       m_abort = use2 ? abort_b : abort_a;
    wire [9:0] m_x     = use2 ? px_b    : px_a;
    wire [9:0] m_y     = use2 ? py_b    : py_a;
    wire [3:0] m_col   = use2 ? col_b   : col_a;

    int checks = 0;
    int errors = 0;

    logic [19:0] pix_q[$];
    int          first_cyc, last_cyc, done_cyc, stall_bad;
    logic        done_seen, abort_seen, rdy_after;
    logic [3:0]  col_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
        @(negedge clk);
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1); color = 4'(c);
        seg_valid = 1'b1;
        check("accept_ready", m_ready, 1);
        @(negedge clk);
        seg_valid = 1'b0;
        check("setup_no_pix", m_valid, 0);
        check("busy_not_ready", m_ready, 0);
    endtask

    task automatic collect(input int budget, input bit toggle);
        logic        had_stall;
        logic [19:0] stall_xy;
        pix_q.delete();
        done_seen = 0; abort_seen = 0; stall_bad = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        had_stall = 0; stall_xy = '0; col_seen = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            pix_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (m_valid) begin
                if (had_stall && ({m_x, m_y} !== stall_xy)) stall_bad++;
                if (pix_ready) begin
                    pix_q.push_back({m_x, m_y});
                    if (first_cyc < 0) first_cyc = c;
                    last_cyc  = c;
                    col_seen  = m_col;
                    had_stall = 0;
                end else begin
                    had_stall = 1;
                    stall_xy  = {m_x, m_y};
                end
            end
            if (m_done) begin
                done_seen  = 1;
                abort_seen = m_abort;
                done_cyc   = c;
                break;
            end
        end
        pix_ready = 1'b1;
        check("done_within_budget", done_seen, 1);
        @(negedge clk);
        rdy_after = m_ready;
    endtask

    initial begin
        int bad, found, dcnt;
        rst_n = 1'b0; seg_valid = 1'b0; use2 = 1'b0; pix_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", m_ready, 1);
        check("rst_valid", m_valid, 0);
        check("rst_done", m_done, 0);
        check("rst_abort", m_abort, 0);
        check("rst_xyc", {m_x, m_y, m_col}, 0);
        check("rst_ready_b", rdy_b, 1);
        rst_n = 1'b1;

        // horizontal run, first pixel two cycles after the handshake
        send(0, 0, 3, 0, 5);
        collect(30, 0);
        check("h_count", pix_q.size(), 4);
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== {10'(i), 10'd0}) bad++;
        check("h_pixels", bad, 0);
        check("h_first_cyc", first_cyc, 0);
        check("h_last_cyc", last_cyc, 3);
        check("h_done_cyc", done_cyc, 4);
        check("h_abort", abort_seen, 0);
        check("h_color", col_seen, 5);
        check("h_ready_after", rdy_after, 1);

        // degenerate segment
        send(5, 5, 5, 5, 2);
        collect(20, 0);
        check("pt_count", pix_q.size(), 1);
        if (pix_q.size() > 0) check("pt_pixel", pix_q[0], {10'd5, 10'd5});
        check("pt_abort", abort_seen, 0);

        // partially clipped: y runs -32..160, one step per y, 32 steps dropped
        send(200, -32, 300, 160, 7);
        collect(400, 0);
        check("clip_count", pix_q.size(), 161);
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i][9:0] !== 10'(i)) bad++;
        check("clip_y_seq", bad, 0);
        if (pix_q.size() > 0) begin
            check("clip_first_y", pix_q[0][9:0], 0);
            check("clip_last", pix_q[pix_q.size()-1], {10'd300, 10'd160});
        end
        check("clip_abort", abort_seen, 0);

        // diagonal under toggling backpressure
        send(0, 0, 7, 7, 3);
        collect(60, 1);
        check("diag_count", pix_q.size(), 8);
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== {10'(i), 10'(i)}) bad++;
        check("diag_pixels", bad, 0);
        check("diag_stall_stable", stall_bad, 0);

        // fully off-screen
        send(-10, -10, -2, -5, 1);
        collect(50, 0);
        check("off_count", pix_q.size(), 0);
        check("off_abort", abort_seen, 0);

        // segment request while busy is ignored
        send(10, 10, 13, 10, 9);
        pix_ready = 1'b0;
        x0 = 16'd500; y0 = 16'd500; x1 = 16'd600; y1 = 16'd600; seg_valid = 1'b1;
        @(negedge clk);
        check("busy_ignore_ready", m_ready, 0);
        check("busy_stall_x", m_x, 10);
        @(negedge clk);
        seg_valid = 1'b0;
        collect(30, 0);
        check("busy_count", pix_q.size(), 4);
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== {10'(10 + i), 10'd10}) bad++;
        check("busy_pixels", bad, 0);
        @(negedge clk);
        check("busy_no_restart", m_ready, 1);

        // reset in the middle of a segment
        send(0, 0, 9, 0, 4);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid && m_x == 10'd3) begin
                found = 1;
                break;
            end
        end
        check("rst_mid_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_ready", m_ready, 1);
        check("rst_mid_x", m_x, 0);
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m_done) dcnt++;
        end
        check("rst_mid_no_done", dcnt, 0);
        rst_n = 1'b1;
        send(2, 2, 2, 2, 6);
        collect(20, 0);
        check("rst_new_count", pix_q.size(), 1);
        if (pix_q.size() > 0) check("rst_new_pixel", pix_q[0], {10'd2, 10'd2});

        // step cap on the MAX_LEN=8 instance
        use2 = 1'b1;
        send(0, 0, 100, 0, 8);
        collect(50, 0);
        check("cap_count", pix_q.size(), 8);
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== {10'(i), 10'd0}) bad++;
        check("cap_pixels", bad, 0);
        check("cap_abort", abort_seen, 1);
        check("cap_ready_after", rdy_after, 1);
        use2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
